uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
UART byte receiver, the receive-side partner of uart_byte_tx. Samples the asynchronous serial line Rs232_Rx at 16x the selected baud rate. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) and presents each byte with a one-cycle Rx_Done strobe. Uses the same baud_set encoding as the transmitter, so a TX/RX pair on one clock can be looped back directly.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; sets the oversample divisors.

Ports:
clk  in  1  system clock; all logic on rising edge
Rst  in  1  asynchronous reset, active-high
Rs232_Rx  in  1  serial input; idle high; asynchronous to clk
baud_set  in  3  0:9600, 1:19200, 2:38400, 3:57600, 4:115200, 5-7:115200
data_byte  out  8  last correctly received byte
Rx_Done  out  1  one-cycle pulse when a good frame's byte is written to data_byte
uart_state  out  1  high while a frame is being received
frame_err  out  1  one-cycle pulse when a frame ends with stop bit sampled low

Behaviour:
- Reset (async, Rst=1): data_byte=8'h00, Rx_Done=0, uart_state=0, frame_err=0; synchronizer flops=1; all counters=0.
- Rs232_Rx passes through a 2-FF synchronizer plus one delay register. Start condition is a falling edge (prev=1, cur=0) while uart_state=0.
- Oversample divisor DR = floor(CLK_FREQ/(16*baud)) - 1. At 50 MHz: 324, 161, 80, 53, 26. A tick fires when div_cnt==DR; div_cnt then wraps to 0.
- baud_set is latched on the start-detect cycle. Changes during a frame are ignored.
- Start detect cycle: uart_state goes to 1 on the next edge. div_cnt and tick index t are cleared. t counts ticks 0..153.
- Bit k (0=start, 1..8=data d0..d7, 9=stop) is sampled at ticks t=16k+6, 16k+7, 16k+8. The bit value is the majority of the 3 samples.
- False start: if the start-bit majority is 1 (evaluated after t=8), abort. uart_state returns to 0, no Rx_Done, no frame_err; return to idle and wait for the next falling edge.
- Data bits shift into an internal register LSB first. data_byte is not touched until the frame completes.
- Frame end at t=153:
  - stop majority 1: data_byte updated and Rx_Done=1 on the same edge, for exactly one cycle.
  - stop majority 0: frame_err=1 for one cycle; data_byte keeps its old value; Rx_Done stays 0.
  - In both cases uart_state=0 on that edge.
- Ending at t=153 (mid stop bit) lets a back-to-back start edge be caught with no lost frame.
- Falling edges on the line while uart_state=1 are ignored. Sampling only happens at the defined ticks.
- Rx_Done and frame_err are never high in the same cycle.
- Reset asserted mid-frame aborts immediately to the reset values. No partial byte is emitted.
- Latency: the line's falling edge reaches the start-detect cycle after 3 clk cycles (2 synchronizer flops + edge register). At 115200 (27 clk/tick), Rx_Done follows the line's falling edge by 3 + 154*27 ± 1 clk.

Test Plan:
- baud_set=4, send 8'hAA as 8N1 at 8680 ns/bit -> exactly one Rx_Done pulse; data_byte=8'hAA; frame_err stays 0; uart_state high only for the frame.
- baud_set=4, 8'h55 then 8'hA5 back-to-back with no idle gap -> two Rx_Done pulses, data_byte 8'h55 then 8'hA5.
- baud_set=0, 8'h3C at 104167 ns/bit -> Rx_Done, data_byte=8'h3C. Repeat with ±2% bit-time skew -> same result.
- baud_set=4, line low for 2 us then high (glitch) -> uart_state pulses then returns 0; no Rx_Done, no frame_err; data_byte unchanged. A following 8'h81 frame is received correctly.
- baud_set=4, frame 8'hF0 with stop bit driven low -> frame_err one cycle, no Rx_Done, data_byte keeps its previous value.
- Rst=1 during data bit 4 of 8'hFF -> all outputs reset at once (async). After release, a clean 8'h12 frame gives Rx_Done with data_byte=8'h12.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// one-cycle Rx_Done / frame_err strobes. Shares baud_set encoding with uart_byte_tx.
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       uart_state,
    output logic       frame_err
);

    localparam logic [15:0] Div9600   = 16'(CLK_FREQ / (16 * 9600) - 1);
    localparam logic [15:0] Div19200  = 16'(CLK_FREQ / (16 * 19200) - 1);
    localparam logic [15:0] Div38400  = 16'(CLK_FREQ / (16 * 38400) - 1);
    localparam logic [15:0] Div57600  = 16'(CLK_FREQ / (16 * 57600) - 1);
    localparam logic [15:0] Div115200 = 16'(CLK_FREQ / (16 * 115200) - 1);
    localparam logic [7:0]  LastTick  = 8'd153;

    typedef enum logic [0:0] {StIdle = 1'b0, StRx = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [15:0] div_q, div_d;
    logic [15:0] dr_q, dr_d;
    logic [15:0] dr_sel;
    logic [7:0]  t_q, t_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  shift_q, shift_d;
    logic        stop_q, stop_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;

    logic start_det, tick, vote, false_start, frame_end;
    logic [3:0] bit_idx;

    assign start_det   = (state_q == StIdle) && prev_q && !sync2_q;
    assign tick        = (state_q == StRx) && (div_q == dr_q);
    assign bit_idx     = t_q[7:4];
    assign vote        = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) | (samp_q[0] & sync2_q);
    assign false_start = tick && (t_q == 8'd8) && vote;
    assign frame_end   = tick && (t_q == LastTick);

    always_comb begin
        case (baud_set)
            3'd0:    dr_sel = Div9600;
            3'd1:    dr_sel = Div19200;
            3'd2:    dr_sel = Div38400;
            3'd3:    dr_sel = Div57600;
            default: dr_sel = Div115200;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_det) state_d = StRx;
            StRx:    if (false_start || frame_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        dr_d    = dr_q;
        t_d     = t_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        stop_d  = stop_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (start_det) begin
            div_d = '0;
            t_d   = '0;
            dr_d  = dr_sel;
        end else if (state_q == StRx) begin
            if (tick) begin
                div_d = '0;
                t_d   = t_q + 8'd1;
                if (t_q[3:0] == 4'd6 || t_q[3:0] == 4'd7) begin
                    samp_d = {samp_q[0], sync2_q};
                end
                // Third sample of each bit resolves the vote.
                if (t_q[3:0] == 4'd8) begin
                    if (bit_idx >= 4'd1 && bit_idx <= 4'd8) begin
                        shift_d = {vote, shift_q[7:1]};
                    end else if (bit_idx == 4'd9) begin
                        stop_d = vote;
                    end
                end
                if (frame_end) begin
                    if (stop_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            div_q   <= '0;
            dr_q    <= '0;
            t_q     <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= Rs232_Rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            div_q   <= div_d;
            dr_q    <= dr_d;
            t_q     <= t_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_byte  = data_q;
    assign Rx_Done    = done_q;
    assign frame_err  = ferr_q;
    assign uart_state = state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized bench for uart_byte_rx: frames are generated from baud/bit-time arithmetic and
// the expected event stream (good byte / framing error / nothing) is scoreboarded.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    // 3.6864 MHz divides every supported baud exactly and keeps frames short.
    localparam int unsigned ClkFreq = 3686400;
    localparam real ClkHalf = 1.0e9 / ClkFreq / 2.0;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [2:0] baud;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       uart_state;
    logic       frame_err;

    uart_byte_rx #(.CLK_FREQ(ClkFreq)) dut (
        .clk       (clk),
        .Rst       (rst),
        .Rs232_Rx  (rx),
        .baud_set  (baud),
        .data_byte (data_byte),
        .Rx_Done   (rx_done),
        .uart_state(uart_state),
        .frame_err (frame_err)
    );

    always #(ClkHalf) clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    logic [7:0]  last_good = 8'h00;
    logic        done_prev = 1'b0;
    logic        ferr_prev = 1'b0;
    int unsigned state_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done || frame_err) begin
                check("done_ferr_exclusive", 32'(rx_done & frame_err), 32'd0);
                got_q.push_back({frame_err, data_byte});
            end
            if (rx_done) check("done_width", 32'(done_prev), 32'd0);
            if (frame_err) check("ferr_width", 32'(ferr_prev), 32'd0);
            if (uart_state) state_cycles <= state_cycles + 1;
        end
        done_prev <= rx_done;
        ferr_prev <= frame_err;
    end

    function automatic real bit_ns(input int bsel);
        case (bsel)
            0:       return 1.0e9 / 9600.0;
            1:       return 1.0e9 / 19200.0;
            2:       return 1.0e9 / 38400.0;
            3:       return 1.0e9 / 57600.0;
            default: return 1.0e9 / 115200.0;
        endcase
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int bsel,
                              input int skew_ppt, input bit scramble);
        real bt;
        bt = bit_ns(bsel) * real'(1000 + skew_ppt) / 1000.0;
        baud = 3'(bsel);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (scramble && i == 0) baud = 3'($urandom_range(0, 7));
            #(bt);
        end
        baud = 3'(bsel);
        rx = stop_ok;
        #(bt);
        rx = 1'b1;
        if (stop_ok) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
    endtask

    task automatic check_events();
        repeat (8) @(negedge clk);
        check("event_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check("event", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
        check("data_byte_hold", 32'(data_byte), 32'(last_good));
        check("state_idle", 32'(uart_state), 32'd0);
    endtask

    task automatic glitch(input real low_ns, input int bsel);
        int unsigned c0;
        baud = 3'(bsel);
        c0 = state_cycles;
        rx = 1'b0;
        #(low_ns);
        rx = 1'b1;
        #(bit_ns(bsel));
        check("glitch_state_pulse", 32'(state_cycles != c0), 32'd1);
        check_events();
    endtask

    initial begin
        int unsigned c0;
        real bt;
        rst  = 1'b1;
        rx   = 1'b1;
        baud = 3'd4;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data_byte), 32'h00);
        check("rst_done", 32'(rx_done), 32'd0);
        check("rst_state", 32'(uart_state), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame; at 2 clk/tick the frame occupies 154 ticks = 308 cycles.
        c0 = state_cycles;
        send_frame(8'hAA, 1'b1, 4, 0, 1'b0);
        check("state_len_115200", 32'(state_cycles - c0 >= 306 && state_cycles - c0 <= 310), 32'd1);
        check_events();

        send_frame(8'h55, 1'b1, 4, 0, 1'b0);
        send_frame(8'hA5, 1'b1, 4, 0, 1'b0);
        check_events();

        c0 = state_cycles;
        send_frame(8'h3C, 1'b1, 0, 0, 1'b1);
        check("state_len_9600", 32'(state_cycles - c0 >= 3694 && state_cycles - c0 <= 3698), 32'd1);
        check_events();
        send_frame(8'h3C, 1'b1, 0, 20, 1'b0);
        check_events();
        send_frame(8'h3C, 1'b1, 0, -20, 1'b0);
        check_events();

        glitch(2000.0, 4);
        send_frame(8'h81, 1'b1, 4, 0, 1'b0);
        check_events();

        send_frame(8'hF0, 1'b0, 4, 0, 1'b0);
        check_events();
        #(bit_ns(4));

        // Reset in the middle of data bit 4 of 8'hFF.
        bt = bit_ns(4);
        baud = 3'd4;
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            #(bt);
        end
        #(bt / 2.0);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(data_byte), 32'h00);
        check("midrst_done", 32'(rx_done), 32'd0);
        check("midrst_state", 32'(uart_state), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        last_good = 8'h00;
        exp_q.delete();
        got_q.delete();
        #(bt * 6.0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b1, 4, 0, 1'b0);
        check_events();

        for (int n = 0; n < 14; n++) begin
            int bsel, kind, skew;
            logic [7:0] b;
            b    = 8'($urandom);
            bsel = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            skew = $urandom_range(0, 40) - 20;
            bt   = bit_ns(bsel);
            if (kind == 0) begin
                glitch(bt * real'($urandom_range(10, 30)) / 100.0, bsel);
            end else if (kind == 1) begin
                send_frame(b, 1'b0, bsel, skew, 1'($urandom_range(0, 1)));
                check_events();
                #(bt);
            end else begin
                send_frame(b, 1'b1, bsel, skew, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 9) >= 3) begin
                    check_events();
                    #(bt * real'($urandom_range(0, 20)) / 10.0);
                end
            end
        end
        check_events();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
